// File: rtl/iport_conditioner.sv
// rtl/iport_conditioner.sv - input-port synchronizer, per-bit debouncer and sticky edge flags
module iport_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  input  logic             clr_we,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [31:0]      iport,
  output logic             event_any
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] level_nxt;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] clr;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];

  // Any sample agreeing with the accepted level restarts the run of disagreements.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      level_nxt[i] = level[i];
      cnt_nxt[i]   = '0;
      if (sync2[i] != level[i]) begin
        if (cnt[i] == CNT_LAST) begin
          level_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  assign clr = clr_we ? clr_mask : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      rise  <= '0;
      fall  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      level <= level_nxt;
      // Set is OR-ed after the clear so a same-edge event is never lost.
      rise  <= (rise & ~clr) | (level_nxt & ~level);
      fall  <= (fall & ~clr) | (~level_nxt & level);
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign iport     = {8'h00, 8'(fall), 8'(rise), 8'(level)};
  assign event_any = (|rise) | (|fall);

endmodule
